// File: rtl/urate_pkg.sv
// urate_pkg: shared encodings and the rate-exponent clamp for the up-rate interpolator.
package urate_pkg;
    typedef enum logic [1:0] {
        MODE_ZERO = 2'd0,
        MODE_HOLD = 2'd1,
        MODE_LIN  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    function automatic int clamp_rate(input int r, input int lmax);
        return (r > lmax) ? lmax : r;
    endfunction
endpackage

// File: rtl/urate_lerp.sv
// urate_lerp: combinational output sample for phase k of a burst (zero-stuff, hold or linear).
module urate_lerp
    import urate_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int LMAX   = 5,
    parameter int LW     = 3
) (
    input  logic signed [DWIDTH-1:0] prev,
    input  logic signed [DWIDTH-1:0] cur,
    input  logic        [LMAX-1:0]   k,
    input  logic        [LW-1:0]     l,
    input  mode_e                    mode,
    output logic signed [DWIDTH-1:0] out
);
    localparam int PW = DWIDTH + 1 + LMAX;

    logic signed [DWIDTH:0] diff;
    logic signed [PW-1:0]   prod;

    // The arithmetic shift floors; the result always lies between prev and cur, so truncation is exact.
    always_comb begin
        diff = {cur[DWIDTH-1], cur} - {prev[DWIDTH-1], prev};
        prod = PW'(diff) * PW'(k);
        out  = (mode == MODE_LIN)                 ? DWIDTH'(PW'(prev) + (prod >>> l)) :
               (mode == MODE_ZERO && k != '0)     ? '0 : cur;
    end
endmodule

// File: rtl/urate_interp.sv
// urate_interp: power-of-two up-rate with valid/ready input; emits 2^rate_log2 outputs per sample.
module urate_interp
    import urate_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int LMAX   = 5,
    parameter int LW     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic        [LW-1:0]     rate_log2,
    input  logic        [1:0]        mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] in,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] out
);
    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic        [LMAX-1:0]   k_q, k_d;
    logic        [LW-1:0]     l_q, l_d;
    logic signed [DWIDTH-1:0] prev_q, prev_d, cur_q, cur_d, out_q, out_d, lerp;
    logic                     out_valid_q, out_valid_d, last, xfer;

    always_comb begin
        last     = k_q == LMAX'((1 << l_q) - 1);
        in_ready = state_q == ST_IDLE || last;
        xfer     = in_valid && in_ready;
        state_d  = xfer ? ST_BURST : last ? ST_IDLE : state_q;
        k_d      = xfer ? '0 : (state_q == ST_BURST && !last) ? k_q + LMAX'(1) : k_q;
        l_d      = xfer ? LW'(clamp_rate(int'(rate_log2), LMAX)) : l_q;
        mode_d   = xfer ? mode_e'(mode) : mode_q;
        cur_d    = xfer ? in : cur_q;
        prev_d   = xfer ? cur_q : prev_q;
    end

    // Fed from the next-state values so the registered output lines up with the phase it belongs to.
    urate_lerp #(.DWIDTH(DWIDTH), .LMAX(LMAX), .LW(LW)) u_lerp (
        .prev (prev_d),
        .cur  (cur_d),
        .k    (k_d),
        .l    (l_d),
        .mode (mode_d),
        .out  (lerp)
    );

    always_comb begin
        out_valid_d = state_d == ST_BURST;
        out_d       = out_valid_d ? lerp : out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ZERO;
            k_q         <= '0;
            l_q         <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            l_q         <= l_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
endmodule

// File: tb/tb_urate_interp.sv
// tb_urate_interp: scoreboard bench; expected bursts are computed from the sample rules with plain integer math.
module tb_urate_interp;
    logic               clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid;
    logic        [2:0]  rate_log2 = '0;
    logic        [1:0]  mode = '0;
    logic signed [15:0] in = '0, out;

    int sb[$];
    int cur_m = 0, last_out = 0, passed = 0, total = 0;

    urate_interp #(.DWIDTH(16), .LMAX(5), .LW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .rate_log2 (rate_log2),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    endtask

    function automatic int floor_div(input int n, input int d);
        return (n >= 0) ? n / d : -((-n + d - 1) / d);
    endfunction

    // Reference: one burst of 2^min(r,5) samples, interpolating from the previous accepted sample.
    task automatic push(input int x, input int r, input int m);
        int n = 1 << ((r > 5) ? 5 : r);
        for (int k = 0; k < n; k++)
            sb.push_back((m == 2) ? cur_m + floor_div((x - cur_m) * k, n) :
                         (m == 0 && k != 0) ? 0 : x);
        cur_m = x;
    endtask

    task automatic step(input bit v, input int x, input int r, input int m, output bit took);
        @(negedge clk);
        #1;
        took = v && sb.size() == 0;
        chk("in_ready", in_ready, sb.size() == 0);
        in_valid  = v;
        in        = 16'(x);
        rate_log2 = 3'(r);
        mode      = 2'(m);
        if (took) push(x, r, m);
    endtask

    task automatic send(input int x, input int r, input int m);
        bit t = 1'b0;
        for (int i = 0; i < 40 && !t; i++) step(1'b1, x, r, m, t);
        chk("send_accepted", t, 1);
    endtask

    task automatic idle();
        bit t;
        for (int i = 0; i < 40 && sb.size() != 0; i++)
            step(1'b0, 0, $urandom_range(0, 7), $urandom_range(0, 3), t);
        step(1'b0, 0, 0, 0, t);
        chk("drain", sb.size(), 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_out = 0;
        end else begin
            chk("out_valid", out_valid, sb.size() != 0);
            if (out_valid && sb.size() != 0) chk("out", out, sb.pop_front());
            else if (!out_valid) chk("out_hold", out, last_out);
            last_out = out;
        end
    end

    initial begin
        bit t;
        logic signed [15:0] rx;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_in_ready", in_ready, 1);
        #1 rst = 1'b0;

        send(100, 2, 2);
        send(-100, 2, 2);
        idle();
        send(0, 1, 2);
        send(-3, 1, 2);
        idle();
        send(1234, 3, 0);
        idle();
        send(1234, 3, 1);
        idle();
        send(77, 2, 1);
        idle();
        send(5, 7, 1);
        idle();
        send(300, 2, 2);
        step(1'b0, 9, 0, 0, t);
        step(1'b0, 9, 5, 1, t);
        send(500, 1, 0);
        send(-700, 0, 2);
        send(-700, 0, 1);
        idle();

        // Reset while the burst sits at phase 1.
        send(100, 2, 2);
        step(1'b0, 0, 2, 2, t);
        step(1'b0, 0, 2, 2, t);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        chk("midrst_in_ready", in_ready, 1);
        sb.delete();
        cur_m = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        send(40, 2, 2);
        idle();

        for (int i = 0; i < 300; i++) begin
            rx = 16'($urandom);
            step($urandom_range(0, 99) < 70, int'(rx), $urandom_range(0, 7), $urandom_range(0, 3), t);
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule
